// File: rtl/red_sched_pkg.sv
// Shared definitions for the RED nibble-reduction sequencer: state encoding,
// latency constant and a nibble-select helper.
package red_sched_pkg;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'd0,
    RS_PAIR  = 2'd1,
    RS_ACC   = 2'd2,
    RS_FINAL = 2'd3
  } rs_state_e;

  localparam int unsigned RED_LATENCY = 7;

  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] k);
    return v[{k, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/red_sched_if.sv
// Execute-stage handshake between the ALU issue logic and the RED sequencer.
interface red_sched_if;
  logic        start;
  logic        cancel;
  logic [15:0] alu_in1;
  logic [15:0] alu_in2;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (output start, cancel, alu_in1, alu_in2,
                  input  busy, done, out);
  modport slave  (input  start, cancel, alu_in1, alu_in2,
                  output busy, done, out);
endinterface

// File: rtl/red_sched_adder.sv
// Plain 4-bit ripple-carry adder; the RED sequencer shares one instance.
module four_bit_ripple_carry (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/red_sched.sv
// RED sequencer: reduces the eight nibbles of two operands mod 16 over seven
// clocks using one shared 4-bit adder (4 pair sums, 2 accumulations, 1 final).
module red_sched
  import red_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  red_sched_if.slave  bus
);

  rs_state_e   state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        busy_q;

  logic [15:0] op1_q, op2_q;
  logic [3:0]  r_q [4];
  logic [3:0]  a_q [2];
  logic [15:0] out_q;
  logic        done_q;

  logic [3:0]  add_a, add_b, add_sum;
  logic        adder_cout_unused;
  logic        accept, r_we, a_we, out_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RS_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != RS_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RS_IDLE: begin
        if (bus.start && !bus.cancel) begin
          state_d = RS_PAIR;
          idx_d   = '0;
        end
      end
      RS_PAIR: begin
        if (idx_q == 2'd3) begin
          state_d = RS_ACC;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      RS_ACC: begin
        if (idx_q == 2'd1) begin
          state_d = RS_FINAL;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      RS_FINAL: state_d = RS_IDLE;
      default:  state_d = RS_IDLE;
    endcase
    if (bus.cancel && state_q != RS_IDLE) begin
      state_d = RS_IDLE;
      idx_d   = '0;
    end
  end

  // Adder operands depend only on state and index; each stage's result is
  // written back on the same edge it is produced.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    r_we   = 1'b0;
    a_we   = 1'b0;
    out_we = 1'b0;
    accept = (state_q == RS_IDLE) && bus.start && !bus.cancel;
    case (state_q)
      RS_PAIR: begin
        add_a = nibble(op1_q, idx_q);
        add_b = nibble(op2_q, idx_q);
        r_we  = 1'b1;
      end
      RS_ACC: begin
        add_a = r_q[{idx_q[0], 1'b0}];
        add_b = r_q[{idx_q[0], 1'b1}];
        a_we  = 1'b1;
      end
      RS_FINAL: begin
        add_a  = a_q[0];
        add_b  = a_q[1];
        out_we = !bus.cancel;
      end
      default: ;
    endcase
  end

  four_bit_ripple_carry u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (adder_cout_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op1_q  <= '0;
      op2_q  <= '0;
      r_q    <= '{default: '0};
      a_q    <= '{default: '0};
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        op1_q <= bus.alu_in1;
        op2_q <= bus.alu_in2;
      end
      if (r_we) r_q[idx_q] <= add_sum;
      if (a_we) a_q[idx_q[0]] <= add_sum;
      if (out_we) out_q <= {12'b0, add_sum};
      done_q <= out_we;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

// File: tb/tb_red_sched.sv
// Directed bench for red_sched: expected results are queued at start and
// popped by a monitor on every done pulse.
module tb_red_sched;
  import red_sched_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   failed = 0;
  logic [15:0] exp_q[$];
  int   n;

  red_sched_if sif();

  red_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!sif.done && cycles < 40) begin
      step();
      cycles++;
    end
    if (!sif.done) begin
      tests++;
      failed++;
      $display("FAIL done_timeout: no done after %0d cycles", cycles);
    end
  endtask

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    sif.alu_in1 = x;
    sif.alu_in2 = y;
    sif.start   = 1'b1;
    step();
    sif.start   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && sif.done) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: out=%h, expected no completion", sif.out);
      end else begin
        chk("result", sif.out, exp_q.pop_front());
      end
    end
  end

  initial begin
    sif.start   = 1'b0;
    sif.cancel  = 1'b0;
    sif.alu_in1 = '0;
    sif.alu_in2 = '0;
    repeat (3) step();
    chk("reset_busy", {15'b0, sif.busy}, 16'h0);
    chk("reset_done", {15'b0, sif.done}, 16'h0);
    chk("reset_out",  sif.out, 16'h0000);
    rst_n = 1'b1;
    step();

    // Basic: 1+2+3+4+5+6+7+8 = 36 -> 4
    exp_q.push_back(16'h0004);
    issue(16'h1234, 16'h5678);
    n = 0;
    while (sif.busy && n < 40) begin
      n++;
      step();
    end
    chk("busy_cycles", 16'(n), 16'(RED_LATENCY));
    chk("done_after_busy", {15'b0, sif.done}, 16'h1);
    step();
    chk("done_one_cycle", {15'b0, sif.done}, 16'h0);
    chk("out_held", sif.out, 16'h0004);

    // Saturating: 8 * 15 = 120 -> 8; every pair sum wraps to E
    exp_q.push_back(16'h0008);
    issue(16'hFFFF, 16'hFFFF);
    repeat (4) step();
    for (int k = 0; k < 4; k++) chk($sformatf("pair%0d", k), {12'b0, dut.r_q[k]}, 16'h000E);
    wait_done(n);
    chk("sat_latency", 16'(n), 16'd3);
    step();

    // Start while busy is ignored; eight nibbles of 1 -> 8
    exp_q.push_back(16'h0008);
    issue(16'h1111, 16'h1111);
    step();
    step();
    issue(16'hFFFF, 16'hFFFF);
    wait_done(n);
    chk("ignored_start_latency", 16'(n), 16'd4);
    // Back-to-back start in the done cycle
    exp_q.push_back(16'h0001);
    issue(16'h0001, 16'h0000);
    chk("b2b_done_drops", {15'b0, sif.done}, 16'h0);
    chk("b2b_busy", {15'b0, sif.busy}, 16'h1);
    wait_done(n);
    chk("b2b_latency", 16'(n), 16'(RED_LATENCY));
    step();

    // Cancel during ACC 0: no done, out keeps 0001
    issue(16'h2222, 16'h3333);
    repeat (4) step();
    sif.cancel = 1'b1;
    step();
    sif.cancel = 1'b0;
    chk("cancel_busy", {15'b0, sif.busy}, 16'h0);
    chk("cancel_done", {15'b0, sif.done}, 16'h0);
    repeat (10) step();
    chk("cancel_out_kept", sif.out, 16'h0001);
    // 0+1+2+3+4+5+6+7 = 28 -> C
    exp_q.push_back(16'h000C);
    issue(16'h0123, 16'h4567);
    wait_done(n);
    chk("post_cancel_latency", 16'(n), 16'(RED_LATENCY));
    step();

    // Reset during PAIR 2
    issue(16'hAAAA, 16'h5555);
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("rst_mid_busy", {15'b0, sif.busy}, 16'h0);
    chk("rst_mid_done", {15'b0, sif.done}, 16'h0);
    chk("rst_mid_out",  sif.out, 16'h0000);
    rst_n = 1'b1;
    step();

    // start and cancel together in IDLE: not accepted
    sif.cancel = 1'b1;
    issue(16'h1234, 16'h5678);
    sif.cancel = 1'b0;
    chk("simul_busy", {15'b0, sif.busy}, 16'h0);
    repeat (9) step();
    chk("simul_out", sif.out, 16'h0000);

    step();
    chk("pending_results", 16'(exp_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
